accumulate_saturate: RTL and testbench

ACCUMULATE_SATURATE -- requirements
Module: accumulate_saturate

---
 rtl/accumulate_saturate.sv | 61 ++++++
 tb/tb_accumulate_saturate.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulate_saturate.sv
// accumulate_saturate: sums fixed-length blocks of unsigned samples, clamping at full scale, and holds each total until taken.
module accumulate_saturate #(
  parameter int IN_W  = 36,
  parameter int ACC_W = 48,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_result,
  input  logic             in_overflow,
  input  logic [CNT_W-1:0] block_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_saturated
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic sat_q;
  logic [ACC_W:0] sample, sum;
  assign sample = {{(ACC_W-IN_W){1'b0}}, in_overflow, in_result};
  assign sum = {1'b0, acc_q} + sample;
  assign cnt_d = cnt_q + CNT_W'(1);
  assign len_d = block_len == '0 ? CNT_W'(1) : block_len;
  assign in_ready = !reset && state_q != HOLD;
  assign out_valid = state_q == HOLD;
  assign out_sum = acc_q;
  assign out_saturated = sat_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      sat_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          acc_q <= sample[ACC_W-1:0];
          cnt_q <= CNT_W'(1);
          len_q <= len_d;
          sat_q <= 1'b0;
          state_q <= len_d == CNT_W'(1) ? HOLD : ACCUM;
        end
        ACCUM: if (in_valid) begin
          // a carry out of the ACC_W-bit sum means the total no longer fits
          acc_q <= (sum[ACC_W] || sat_q) ? '1 : sum[ACC_W-1:0];
          sat_q <= sat_q | sum[ACC_W];
          cnt_q <= cnt_d;
          if (cnt_d == len_q) state_q <= HOLD;
        end
        HOLD: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_accumulate_saturate.sv
// tb_accumulate_saturate: directed and randomized checks of two accumulate_saturate instances (ACC_W 48 and 38) against a block-total model.
module tb_accumulate_saturate;
  typedef logic [36:0] smp_t;
  logic clk = 0, reset = 1, in_valid = 0, in_overflow = 0, out_ready = 0;
  logic [35:0] in_result = '0;
  logic [7:0] block_len = '0;
  logic rdy_a, ov_a, ot_a, rdy_b, ov_b, ot_b;
  logic [47:0] os_a;
  logic [37:0] os_b;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  accumulate_saturate dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_a), .in_result(in_result),
    .in_overflow(in_overflow), .block_len(block_len), .out_valid(ov_a), .out_ready(out_ready),
    .out_sum(os_a), .out_saturated(ot_a));
  accumulate_saturate #(.ACC_W(38)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_b), .in_result(in_result),
    .in_overflow(in_overflow), .block_len(block_len), .out_valid(ov_b), .out_ready(out_ready),
    .out_sum(os_b), .out_saturated(ot_b));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_smp(input smp_t s);
    {in_overflow, in_result} = s;
  endtask
  // block total is the plain sum clamped once at full scale, returned as {saturated, value}
  function automatic logic [64:0] ref_sum(input smp_t s[$], input int w);
    logic [63:0] t, m;
    t = '0;
    m = (64'd1 << w) - 64'd1;
    foreach (s[i]) t += 64'(s[i]);
    return t > m ? {1'b1, m} : {1'b0, t};
  endfunction
  task automatic drive(input smp_t s[$], input logic [7:0] bl, input int gap, output bit early);
    early = 0;
    foreach (s[i]) begin
      while ($urandom_range(0, 99) < gap) begin
        in_valid = 0;
        set_smp(smp_t'({$urandom, $urandom}));
        early |= ov_a | ov_b;
        tick;
      end
      in_valid = 1;
      set_smp(s[i]);
      block_len = i == 0 ? bl : 8'($urandom);
      early |= ov_a | ov_b | !rdy_a | !rdy_b;
      tick;
    end
    in_valid = 0;
  endtask
  task automatic test_reset;
    reset = 1;
    in_valid = 1;
    set_smp(37'd99);
    block_len = 8'd1;
    tick;
    tick;
    n_vec++;
    if ({rdy_a, rdy_b, ov_a, ov_b, ot_a, ot_b, os_a, os_b} !== '0) begin
      n_err++;
      $display("FAIL reset_outs: rdy=%b%b valid=%b%b sat=%b%b sum=%0h/%0h want all 0", rdy_a, rdy_b, ov_a, ov_b, ot_a, ot_b, os_a, os_b);
    end
    reset = 0;
    in_valid = 0;
    #1;
    n_vec++;
    if ({rdy_a, rdy_b} !== 2'b11) begin
      n_err++;
      $display("FAIL ready_after_reset: got %b%b want 11", rdy_a, rdy_b);
    end
    tick;
    n_vec++;
    if ({ov_a, ov_b} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_sample_ignored: valid=%b%b want 00", ov_a, ov_b);
    end
  endtask
  task automatic test_basic;
    smp_t q[$];
    bit early;
    q = {37'd10, 37'd20, 37'd30};
    out_ready = 1;
    drive(q, 8'd3, 0, early);
    n_vec++;
    if (early) begin
      n_err++;
      $display("FAIL basic_early: valid before last accept or not ready, got 1 want 0");
    end
    n_vec++;
    if ({ov_a, ot_a, os_a} !== {1'b1, 1'b0, 48'd60} || {ov_b, ot_b, os_b} !== {1'b1, 1'b0, 38'd60}) begin
      n_err++;
      $display("FAIL basic_sum: got v=%b%b sat=%b%b sum=%0d/%0d want v=11 sat=00 sum=60", ov_a, ov_b, ot_a, ot_b, os_a, os_b);
    end
    tick;
    n_vec++;
    if ({ov_a, ov_b} !== 2'b00) begin
      n_err++;
      $display("FAIL basic_one_cycle: valid=%b%b want 00", ov_a, ov_b);
    end
  endtask
  task automatic test_len_zero;
    out_ready = 1;
    block_len = 8'd0;
    in_valid = 1;
    set_smp({1'b1, 36'd5});
    tick;
    in_valid = 0;
    n_vec++;
    if ({ov_a, ot_a, os_a} !== {1'b1, 1'b0, 48'h10_0000_0005} || {ov_b, ot_b, os_b} !== {1'b1, 1'b0, 38'h10_0000_0005}) begin
      n_err++;
      $display("FAIL len_zero: got v=%b%b sat=%b%b sum=%0h/%0h want v=11 sat=00 sum=1000000005", ov_a, ov_b, ot_a, ot_b, os_a, os_b);
    end
    tick;
  endtask
  task automatic test_saturate;
    smp_t q[$];
    bit early;
    q = {'1, '1, '1, '1};
    out_ready = 1;
    drive(q, 8'd4, 0, early);
    n_vec++;
    if ({ov_a, ot_a, os_a} !== {1'b1, 1'b0, 48'h7F_FFFF_FFFC}) begin
      n_err++;
      $display("FAIL sat_wide: got v=%b sat=%b sum=%0h want v=1 sat=0 sum=7ffffffffc", ov_a, ot_a, os_a);
    end
    n_vec++;
    if ({ov_b, ot_b, os_b} !== {1'b1, 1'b1, 38'h3F_FFFF_FFFF}) begin
      n_err++;
      $display("FAIL sat_clamp: got v=%b sat=%b sum=%0h want v=1 sat=1 sum=3fffffffff", ov_b, ot_b, os_b);
    end
    tick;
  endtask
  task automatic test_backpressure;
    smp_t v[4];
    logic [63:0] e;
    foreach (v[i]) v[i] = 37'($urandom);
    out_ready = 0;
    block_len = 8'd2;
    in_valid = 1;
    set_smp(v[0]);
    tick;
    set_smp(v[1]);
    tick;
    set_smp(v[2]);
    e = 64'(v[0]) + 64'(v[1]);
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if ({rdy_a, rdy_b, ov_a, ov_b} !== 4'b0011 || 64'(os_a) !== e || 64'(os_b) !== e) begin
        n_err++;
        $display("FAIL hold_stable[%0d]: rdy=%b%b v=%b%b sum=%0h/%0h want rdy=00 v=11 sum=%0h", k, rdy_a, rdy_b, ov_a, ov_b, os_a, os_b, e);
      end
      tick;
    end
    out_ready = 1;
    tick;
    n_vec++;
    if ({rdy_a, rdy_b, ov_a, ov_b} !== 4'b1100) begin
      n_err++;
      $display("FAIL handshake: rdy=%b%b v=%b%b want rdy=11 v=00", rdy_a, rdy_b, ov_a, ov_b);
    end
    tick;
    set_smp(v[3]);
    tick;
    in_valid = 0;
    e = 64'(v[2]) + 64'(v[3]);
    n_vec++;
    if ({ov_a, ov_b} !== 2'b11 || 64'(os_a) !== e || 64'(os_b) !== e) begin
      n_err++;
      $display("FAIL next_block: v=%b%b sum=%0h/%0h want v=11 sum=%0h", ov_a, ov_b, os_a, os_b, e);
    end
    tick;
  endtask
  task automatic test_reset_mid;
    out_ready = 1;
    block_len = 8'd4;
    in_valid = 1;
    set_smp(37'd100);
    tick;
    set_smp(37'd200);
    tick;
    reset = 1;
    set_smp(37'd300);
    tick;
    n_vec++;
    if ({rdy_a, rdy_b, ov_a, ov_b} !== 4'b0000 || os_a !== '0 || os_b !== '0) begin
      n_err++;
      $display("FAIL mid_reset: rdy=%b%b v=%b%b sum=%0h/%0h want all 0", rdy_a, rdy_b, ov_a, ov_b, os_a, os_b);
    end
    reset = 0;
    out_ready = 0;
    block_len = 8'd1;
    set_smp(37'd7);
    tick;
    in_valid = 0;
    n_vec++;
    if ({ov_a, ot_a, os_a} !== {1'b1, 1'b0, 48'd7} || {ov_b, ot_b, os_b} !== {1'b1, 1'b0, 38'd7}) begin
      n_err++;
      $display("FAIL after_abort: v=%b%b sum=%0d/%0d want v=11 sum=7", ov_a, ov_b, os_a, os_b);
    end
    reset = 1;
    tick;
    reset = 0;
    tick;
    n_vec++;
    if ({ov_a, ov_b, rdy_a, rdy_b} !== 4'b0011) begin
      n_err++;
      $display("FAIL hold_reset: v=%b%b rdy=%b%b want v=00 rdy=11", ov_a, ov_b, rdy_a, rdy_b);
    end
    out_ready = 1;
  endtask
  task automatic test_gaps;
    bit pat[6] = '{1, 0, 0, 1, 0, 1};
    smp_t vals[3] = '{37'd1, 37'd2, 37'd4};
    int j = 0;
    bit early = 0;
    out_ready = 1;
    foreach (pat[k]) begin
      in_valid = pat[k];
      if (pat[k]) set_smp(vals[j++]);
      else set_smp(smp_t'({$urandom, $urandom}));
      block_len = k == 0 ? 8'd3 : 8'd9;
      early |= ov_a | ov_b;
      tick;
    end
    in_valid = 0;
    n_vec++;
    if (early) begin
      n_err++;
      $display("FAIL gaps_early: valid before block end, got 1 want 0");
    end
    n_vec++;
    if ({ov_a, ot_a, os_a} !== {1'b1, 1'b0, 48'd7} || {ov_b, ot_b, os_b} !== {1'b1, 1'b0, 38'd7}) begin
      n_err++;
      $display("FAIL gaps_sum: v=%b%b sat=%b%b sum=%0d/%0d want v=11 sat=00 sum=7", ov_a, ov_b, ot_a, ot_b, os_a, os_b);
    end
    tick;
  endtask
  task automatic test_len255;
    smp_t q[$];
    bit early;
    for (int i = 0; i < 255; i++) q.push_back('1);
    out_ready = 1;
    drive(q, 8'd255, 0, early);
    n_vec++;
    if (early) begin
      n_err++;
      $display("FAIL len255_early: valid before 255th sample, got 1 want 0");
    end
    n_vec++;
    if ({ov_a, ot_a, 64'(os_a)} !== {1'b1, ref_sum(q, 48)} || {ov_b, ot_b, 64'(os_b)} !== {1'b1, ref_sum(q, 38)}) begin
      n_err++;
      $display("FAIL len255_sum: v=%b%b sat=%b%b sum=%0h/%0h want %0h/%0h", ov_a, ov_b, ot_a, ot_b, os_a, os_b, ref_sum(q, 48), ref_sum(q, 38));
    end
    tick;
  endtask
  task automatic test_random;
    for (int b = 0; b < 40; b++) begin
      smp_t q[$];
      bit early;
      int lf, n, stall;
      logic [63:0] r;
      lf = $urandom_range(0, 12);
      n = lf == 0 ? 1 : lf;
      for (int i = 0; i < n; i++) begin
        r = {$urandom, $urandom};
        q.push_back($urandom_range(0, 1) ? r[36:0] : 37'(r[15:0]));
      end
      out_ready = 0;
      drive(q, 8'(lf), 30, early);
      n_vec++;
      if (early) begin
        n_err++;
        $display("FAIL rand_early[%0d]: valid early or not ready, got 1 want 0", b);
      end
      stall = $urandom_range(0, 3);
      repeat (stall) tick;
      n_vec++;
      if ({ov_a, ot_a, 64'(os_a)} !== {1'b1, ref_sum(q, 48)}) begin
        n_err++;
        $display("FAIL rand_a[%0d]: v=%b sat=%b sum=%0h want %0h", b, ov_a, ot_a, os_a, ref_sum(q, 48));
      end
      n_vec++;
      if ({ov_b, ot_b, 64'(os_b)} !== {1'b1, ref_sum(q, 38)}) begin
        n_err++;
        $display("FAIL rand_b[%0d]: v=%b sat=%b sum=%0h want %0h", b, ov_b, ot_b, os_b, ref_sum(q, 38));
      end
      out_ready = 1;
      tick;
      n_vec++;
      if ({ov_a, ov_b} !== 2'b00) begin
        n_err++;
        $display("FAIL rand_done[%0d]: valid=%b%b want 00", b, ov_a, ov_b);
      end
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_len_zero;
    test_saturate;
    test_backpressure;
    test_reset_mid;
    test_gaps;
    test_len255;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
